// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : Shared constants and width helpers for the FIFO read path.
// Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

    // Cycles between a FIFO read request and its data appearing (SHOW_AHEAD off)
    localparam int FIFO_RD_LATENCY = 1;

    // Number of bits needed to encode 'value' distinct states, minimum 1
    function automatic int clogb2_f(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage : common_pkg
`default_nettype wire

// File: rtl/reg_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module      : reg_fifo_buf
// Description : Small register FIFO with simultaneous push/pop at any
//               occupancy, head-data output and overflow-drop indication.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_fifo_buf
    import common_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 3,
    localparam int OCC_W = clogb2_f(DEPTH + 1),
    localparam int PTR_W = clogb2_f(DEPTH)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [DW-1:0]    head_data,
    output logic             empty,
    output logic             drop
);

    localparam logic [OCC_W-1:0] C_OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;

    logic w_full;
    logic w_pop;
    logic w_push;

    // Depth need not be a power of two, so the wrap is an explicit compare
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees a slot in the same cycle, so a push into a full buffer is
    // accepted when paired with a pop; otherwise it is dropped
    always_comb begin
        w_full = (r_occ == C_OCC_FULL);
        w_pop  = pop && (r_occ != '0);
        w_push = push && (!w_full || w_pop);
        drop   = push && w_full && !w_pop;
    end

    // Storage write at tail; cleared on reset so head data reads zero
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_tail] <= push_data;
        end
    end

    // Head/tail pointers and occupancy bookkeeping
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ       = r_occ;
    assign empty     = (r_occ == '0);
    assign head_data = r_mem[r_head];

endmodule : reg_fifo_buf
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side master for a non-show-ahead FIFO. Issues read
//               requests against available buffer credit, absorbs the read
//               latency in a register buffer and presents a valid/ready
//               stream with transfer counter and sticky protocol error.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import common_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BUF_DEPTH = 3,   // legal 2..8; >= 3 for one word per cycle
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic             fifo_empty_i,
    output logic             fifo_req_o,
    input  logic             fifo_valid_i,
    input  logic [DW-1:0]    fifo_data_i,
    output logic             m_valid_o,
    output logic [DW-1:0]    m_data_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] xfer_cnt_o,
    output logic             err_o
);

    localparam int OCC_W = clogb2_f(BUF_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;
    localparam logic [SUM_W-1:0] C_DEPTH = SUM_W'(BUF_DEPTH);

    logic [FIFO_RD_LATENCY-1:0] r_inflight;
    logic [CNT_W-1:0]           r_xfer_cnt;
    logic                       r_err;

    logic [OCC_W-1:0] w_occ;
    logic             w_buf_empty;
    logic             w_drop;
    logic             w_pop;
    logic             w_inflight;
    logic [SUM_W-1:0] w_credit_used;
    logic             w_req;
    logic             w_err_set;

    // Credit check uses registered state only; the stream ready never
    // reaches the request path. A word already requested is counted as
    // occupying a slot so the buffer can never overflow.
    always_comb begin
        w_inflight    = |r_inflight;
        w_credit_used = {1'b0, w_occ} + SUM_W'(w_inflight);
        w_req         = en_i && !fifo_empty_i && (w_credit_used < C_DEPTH);
        w_pop         = m_valid_o && m_ready_i;
        w_err_set     = (fifo_valid_i && !w_inflight)
                      || (w_inflight && !fifo_valid_i)
                      || w_drop;
    end

    // Request is held low for the whole time reset is asserted
    assign fifo_req_o = w_req && arstn_i;

    // Track the outstanding request whose data lands next cycle
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= FIFO_RD_LATENCY'(w_req);
        end
    end

    // Completed stream transfers, wrapping naturally
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

    // Sticky protocol error: unsolicited word, lost word or overflow drop
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    reg_fifo_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk_i),
        .arstn     (arstn_i),
        .push      (fifo_valid_i),
        .push_data (fifo_data_i),
        .pop       (w_pop),
        .occ       (w_occ),
        .head_data (m_data_o),
        .empty     (w_buf_empty),
        .drop      (w_drop)
    );

    assign m_valid_o  = !w_buf_empty;
    assign xfer_cnt_o = r_xfer_cnt;
    assign err_o      = r_err;

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Self-checking bench with a queue-based FIFO model and an
//               in-order scoreboard for the stream side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DW        = 32;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             arstn_i;
    logic             en_i;
    logic             fifo_empty_i;
    logic             fifo_req_o;
    logic             fifo_valid_i;
    logic [DW-1:0]    fifo_data_i;
    logic             m_valid_o;
    logic [DW-1:0]    m_data_o;
    logic             m_ready_i;
    logic [CNT_W-1:0] xfer_cnt_o;
    logic             err_o;

    fifo_stream_reader #(
        .DW        (DW),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .en_i         (en_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_req_o   (fifo_req_o),
        .fifo_valid_i (fifo_valid_i),
        .fifo_data_i  (fifo_data_i),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .xfer_cnt_o   (xfer_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO contents and words already read out but not yet transferred
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    int  landed;
    int  xfers;
    bit  model_on;
    bit  suppress_next;
    bit  underflow;
    bit  prev_stall;
    logic [DW-1:0] prev_data;
    int  cyc;
    int  first_req, first_valid, last_valid, valid_cycles;

    typedef struct {
        int nwords;
        int min_cycles;
        int rmode;      // 0 ready high, 1 ready low cycles 3..12, 2 random
        int emode;      // 0 en high, 1 toggle every 2 cycles, 2 random
        int exp_xfer;
        bit exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample/check before the edge, advance the FIFO model after it
    task automatic step();
        logic          s_req, s_val, s_rdy, nv;
        logic [DW-1:0] s_data, nd;
        @(negedge clk);
        s_req  = fifo_req_o;
        s_val  = m_valid_o;
        s_data = m_data_o;
        s_rdy  = m_ready_i;
        if (model_on) begin
            check("req", s_req, (en_i && q.size() != 0 && exp_q.size() < BUF_DEPTH));
            check("m_valid", s_val, (landed > 0));
            if (s_val && exp_q.size() > 0) check("m_data", s_data, exp_q[0]);
            if (prev_stall) check("stall_hold", s_data, prev_data);
            check("xfer_cnt", xfer_cnt_o, xfers);
            check("err_clean", err_o, 0);
        end
        if (s_req && q.size() == 0) underflow = 1'b1;
        if (s_req && first_req < 0) first_req = cyc;
        if (s_val) begin
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
            valid_cycles++;
        end
        prev_stall = s_val && !s_rdy;
        prev_data  = s_data;
        if (s_val && s_rdy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            xfers++;
            landed--;
        end
        if (fifo_valid_i) landed++;
        nv = 1'b0;
        nd = '0;
        if (s_req && q.size() > 0) begin
            nd = q.pop_front();
            if (suppress_next) begin
                suppress_next = 1'b0;
            end else begin
                nv = 1'b1;
                exp_q.push_back(nd);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        fifo_valid_i = nv;
        fifo_data_i  = nd;
        fifo_empty_i = (q.size() == 0);
    endtask

    // Asynchronous reset of DUT and FIFO model; outputs checked immediately
    task automatic do_reset();
        #2;
        arstn_i      = 1'b0;
        en_i         = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_valid_i = 1'b0;
        #1;
        check("rst_req", fifo_req_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_xfer", xfer_cnt_o, 0);
        check("rst_err", err_o, 0);
        q.delete();
        exp_q.delete();
        landed = 0; xfers = 0; prev_stall = 1'b0; underflow = 1'b0;
        suppress_next = 1'b0;
        first_req = -1; first_valid = -1; last_valid = -1; valid_cycles = 0;
        fifo_empty_i = 1'b1;
        en_i         = 1'b0;
        m_ready_i    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        arstn_i = 1'b1;
    endtask

    task automatic run(input int target, input int min_cycles, input int budget,
                       input int rmode, input int emode);
        for (int k = 0; k < budget; k++) begin
            if (k >= min_cycles && xfers >= target && exp_q.size() == 0) break;
            case (rmode)
                1:       m_ready_i = !(k >= 3 && k <= 12);
                2:       m_ready_i = ($urandom_range(0, 3) != 0);
                default: m_ready_i = 1'b1;
            endcase
            case (emode)
                1:       en_i = ((k / 2) % 2 == 0);
                2:       en_i = ($urandom_range(0, 2) != 0);
                default: en_i = 1'b1;
            endcase
            step();
        end
        check("run_complete", xfers, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nwords: 16, min_cycles: 4,  rmode: 0, emode: 0, exp_xfer: 16, exp_err: 1'b0};
        vecs[1] = '{nwords: 8,  min_cycles: 14, rmode: 1, emode: 0, exp_xfer: 8,  exp_err: 1'b0};
        vecs[2] = '{nwords: 0,  min_cycles: 20, rmode: 0, emode: 0, exp_xfer: 0,  exp_err: 1'b0};
        vecs[3] = '{nwords: 10, min_cycles: 4,  rmode: 0, emode: 1, exp_xfer: 10, exp_err: 1'b0};
        vecs[4] = '{nwords: 40, min_cycles: 4,  rmode: 2, emode: 2, exp_xfer: 40, exp_err: 1'b0};
        vecs[5] = '{nwords: 30, min_cycles: 4,  rmode: 2, emode: 0, exp_xfer: 30, exp_err: 1'b0};

        arstn_i = 1'b1; en_i = 1'b0; fifo_empty_i = 1'b1; fifo_valid_i = 1'b0;
        fifo_data_i = '0; m_ready_i = 1'b1; model_on = 1'b0; cyc = 0;
        @(posedge clk);
        #1;

        foreach (vecs[vi]) begin
            do_reset();
            model_on = 1'b1;
            for (int i = 0; i < vecs[vi].nwords; i++) begin
                q.push_back((vi == 0) ? DW'(i) : DW'($urandom));
            end
            fifo_empty_i = (q.size() == 0);
            run(vecs[vi].nwords, vecs[vi].min_cycles, 600, vecs[vi].rmode, vecs[vi].emode);
            repeat (3) step();
            check("vec_xfer_cnt", xfer_cnt_o, vecs[vi].exp_xfer);
            check("vec_err", err_o, vecs[vi].exp_err);
            check("vec_leftover", exp_q.size(), 0);
            check("vec_underflow", underflow, 0);
            if (vecs[vi].rmode == 0 && vecs[vi].emode == 0 && vecs[vi].nwords > 0) begin
                check("latency", first_valid - first_req, 2);
                check("contiguous", last_valid - first_valid + 1, vecs[vi].nwords);
                check("valid_cycles", valid_cycles, vecs[vi].nwords);
            end
            if (vecs[vi].nwords == 0) begin
                check("empty_no_req", first_req, -1);
                check("empty_no_valid", valid_cycles, 0);
            end
        end

        // Unsolicited word: error on the following cycle, sticky until reset
        do_reset();
        model_on     = 1'b0;
        fifo_valid_i = 1'b1;
        fifo_data_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("err_before_edge", err_o, 0);
        @(posedge clk);
        #1;
        fifo_valid_i = 1'b0;
        check("err_unsolicited", err_o, 1);
        repeat (4) step();
        check("err_sticky", err_o, 1);

        // Lost word: a granted request whose data never returns
        do_reset();
        model_on = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(DW'(32'h100 + i));
        fifo_empty_i  = 1'b0;
        suppress_next = 1'b1;
        en_i          = 1'b1;
        repeat (3) step();
        check("err_lost_word", err_o, 1);

        // Reset mid-burst with two buffered words, then normal operation
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 8; i++) q.push_back(DW'(32'h200 + i));
        fifo_empty_i = 1'b0;
        m_ready_i    = 1'b0;
        en_i         = 1'b1;
        for (int k = 0; k < 10 && landed < 2; k++) step();
        check("midburst_occ2", landed, 2);
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 5; i++) q.push_back(DW'(32'h300 + i));
        fifo_empty_i = 1'b0;
        run(5, 4, 200, 0, 0);
        repeat (2) step();
        check("post_reset_xfer", xfer_cnt_o, 5);
        check("post_reset_err", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_stream_reader
`default_nettype wire
